deserializer: RTL

Reassembles a wide word from a sequence of narrow Channel transfers; it is the receive-side counterpart of the serializing stage and sits directly downstream of it on the same clock domain. Chunks arrive least-significant first. Each completed word is written into an output holding register. A separate assembly register lets the next word's chunks be collected while the previous word waits for acknowledge.

---
 rtl/deserializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : deserializer                                               |
// | Description : Reassembles an Nout-bit word from ceil(Nout/Nin) narrow    |
// |               chunks, least-significant chunk first. A separate assembly |
// |               register collects the next word while the previous one     |
// |               waits in the output holding register for acknowledge.      |
// | Ports       : clk    - sole clock, rising edge                           |
// |               reset  - asynchronous active-low reset                     |
// |               flush  - realign to chunk 0 (DESERIALIZER_FLUSH_EN only)   |
// |               in_v/in_d/in_a    - narrow input channel (in_a driven here) |
// |               out_v/out_d/out_a - wide output channel (out_a from sink)  |
// | Options     : define DESERIALIZER_FLUSH_EN to add the flush input.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module deserializer #(
  parameter int Nin  = 16,
  parameter int Nout = 36
) (
  input  logic            clk,
  input  logic            reset,
`ifdef DESERIALIZER_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_v,
  input  logic [Nin-1:0]  in_d,
  output logic            in_a,
  output logic            out_v,
  output logic [Nout-1:0] out_d,
  input  logic            out_a
);

  localparam int D     = (Nout + Nin - 1) / Nin;
  localparam int PW    = (D > 1) ? $clog2(D) : 1;
  localparam int LASTW = Nout - Nin * (D - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(D - 1);

  logic [PW-1:0]   phase;
  logic [Nout-1:0] asm_reg;
  logic [Nout-1:0] hold_reg;
  logic            full;

  logic            flush_now;
  logic            is_last;
  logic            in_xfer;
  logic            out_xfer;
  logic            load;
  logic [Nout-1:0] merged;

`ifdef DESERIALIZER_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign is_last  = (phase == LAST_PHASE);
  // Non-final chunks are always absorbed; the final chunk needs a free
  // holding register, or one being emptied on this same edge.
  assign in_a     = !flush_now && (!is_last || !full || out_a);
  assign in_xfer  = in_v && in_a;
  assign out_xfer = full && out_a;
  assign load     = in_xfer && is_last;

  assign out_v = full;
  assign out_d = hold_reg;

  // Assembly register with the incoming chunk merged into its slot. The
  // final slot may be narrower than Nin; surplus high bits of in_d drop out.
  always_comb begin
    merged = asm_reg;
    for (int i = 0; i < D - 1; i++) begin
      if (phase == PW'(i)) begin
        merged[i*Nin +: Nin] = in_d;
      end
    end
    if (is_last) begin
      merged[Nout-1 -: LASTW] = in_d[LASTW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      asm_reg  <= '0;
      hold_reg <= '0;
      full     <= 1'b0;
    end else begin
      if (flush_now) begin
        phase <= '0;
      end else if (in_xfer) begin
        asm_reg <= merged;
        phase   <= is_last ? '0 : phase + 1'b1;
      end

      // A load while the sink takes the old word keeps full high: no bubble.
      if (load) begin
        hold_reg <= merged;
        full     <= 1'b1;
      end else if (out_xfer) begin
        full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
